// File: rtl/asip_pkg.sv
// Shared types for the fetch front end: instruction classes, word width and fetch FSM states.
package asip_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        INSTR_R = 2'b00,
        INSTR_I = 2'b01,
        INSTR_J = 2'b10,
        INSTR_V = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        FLUSH = 2'b11
    } fetch_state_e;

    // The two top opcode bits select the instruction class.
    function automatic instr_class_e instr_class(input logic [INSTR_W-1:0] word);
        return instr_class_e'(word[INSTR_W-1:INSTR_W-2]);
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection: reset vector, branch redirect, jump target, sequential +4, or hold.
module fetch_pc_gen
    import asip_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            rst,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            capture,
    input  logic            jump,
    input  logic [26:0]     jump_field,
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(32'd4);

    // Priority mux; the sequential add wraps naturally at 2^PC_W.
    always_comb begin
        pc_next = pc;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (br_taken) begin
            pc_next = {br_target[PC_W-1:2], 2'b00};
        end else if (capture && jump) begin
            pc_next = {pc[PC_W-1:29], jump_field, 2'b00};
        end else if (capture) begin
            pc_next = pc + PC_STEP;
        end else begin
            pc_next = pc;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: FSM, PC and decode-register outputs.
// Optional jump predecode on captured J-type words is enabled by macro FETCH_JUMP_PREDECODE_EN.
module fetch_ctrl
    import asip_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [PC_W-1:0]    br_target,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc_out
);

    fetch_state_e       state_r;
    fetch_state_e       state_next_s;
    logic [PC_W-1:0]    pc_r;
    logic [PC_W-1:0]    pc_next_s;
    logic [INSTR_W-1:0] instr_out_r;
    logic [PC_W-1:0]    pc_out_r;
    logic               instr_valid_r;
    logic               fetch_en_s;
    logic               capture_s;
    logic               jump_s;

    // A held valid instruction blocks new requests so nothing returned can be lost.
    assign fetch_en_s = (state_r == FETCH) && !(stall && instr_valid_r) && !rst;
    assign capture_s  = fetch_en_s && imem_ready && !br_taken;

`ifdef FETCH_JUMP_PREDECODE_EN
    assign jump_s = (instr_class(imem_rdata) == INSTR_J);
`else
    assign jump_s = 1'b0;
`endif

    fetch_pc_gen #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .rst        (rst),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .capture    (capture_s),
        .jump       (jump_s),
        .jump_field (imem_rdata[26:0]),
        .pc         (pc_r),
        .pc_next    (pc_next_s)
    );

    // Next-state logic; a redirect overrides every state.
    always_comb begin
        state_next_s = state_r;
        if (br_taken) begin
            state_next_s = FLUSH;
        end else begin
            case (state_r)
                IDLE:    state_next_s = FETCH;
                FETCH:   state_next_s = (stall && instr_valid_r) ? HOLD : FETCH;
                HOLD:    state_next_s = stall ? HOLD : FETCH;
                FLUSH:   state_next_s = FETCH;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State, PC and decode-register update.
    always_ff @(posedge clk) begin
        pc_r <= pc_next_s;
        if (rst) begin
            state_r       <= IDLE;
            instr_out_r   <= {INSTR_W{1'b0}};
            pc_out_r      <= {PC_W{1'b0}};
            instr_valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (br_taken) begin
                instr_valid_r <= 1'b0;
            end else if (capture_s) begin
                instr_out_r   <= imem_rdata;
                pc_out_r      <= pc_r;
                instr_valid_r <= 1'b1;
            end else begin
                instr_valid_r <= instr_valid_r;
            end
        end
    end

    assign imem_req    = fetch_en_s;
    assign imem_addr   = pc_r;
    assign instr_out   = instr_out_r;
    assign pc_out      = pc_out_r;
    assign instr_valid = instr_valid_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed stimulus pushes expected captures, a monitor pops them.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;
    exp_t sb_q[$];

    logic        last_valid = 1'b0;
    logic [31:0] last_out   = 32'h0;
    logic [31:0] last_pc    = 32'h0;
    logic [31:0] exp_jump_addr;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] p);
        exp_t e;
        e.word = w;
        e.pc   = p;
        sb_q.push_back(e);
    endtask

    // Monitor: every newly presented instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid === 1'b1 &&
            (!last_valid || instr_out !== last_out || pc_out !== last_pc)) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_instr: got %h at pc %h expected none", instr_out, pc_out);
            end else begin
                e = sb_q.pop_front();
                if (instr_out !== e.word || pc_out !== e.pc) begin
                    bad++;
                    $display("FAIL instr_pc: got %h@%h expected %h@%h",
                             instr_out, pc_out, e.word, e.pc);
                end
            end
        end
        last_valid = instr_valid;
        last_out   = instr_out;
        last_pc    = pc_out;
    end

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        step(); step();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);

        rst = 1'b0;
        step();
        chk("idle_to_fetch_req", {31'h0, imem_req}, 32'h1);

        // Back-to-back fetch of three words
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b1;
            imem_rdata = 32'h0800_0001 + i;
            chk("seq_addr", imem_addr, 32'(4 * i));
            chk("seq_req", {31'h0, imem_req}, 32'h1);
            push(imem_rdata, 32'(4 * i));
            step();
        end
        chk("seq_valid", {31'h0, instr_valid}, 32'h1);
        chk("seq_next_addr", imem_addr, 32'hC);

        // Stall three cycles with memory offering garbage
        stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_req", {31'h0, imem_req}, 32'h0);
            chk("stall_instr", instr_out, 32'h0800_0003);
            chk("stall_pc_out", pc_out, 32'h8);
            chk("stall_addr", imem_addr, 32'hC);
        end
        stall = 1'b0; imem_ready = 1'b0;
        step();
        chk("resume_req", {31'h0, imem_req}, 32'h1);
        chk("resume_addr", imem_addr, 32'hC);

        // Walk pc up to 0x20
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b1;
            imem_rdata = 32'h0800_0004 + i;
            chk("walk_addr", imem_addr, 32'hC + 32'(4 * i));
            push(imem_rdata, 32'hC + 32'(4 * i));
            step();
        end

        // J-type word at 0x20
`ifdef FETCH_JUMP_PREDECODE_EN
        exp_jump_addr = 32'h40;
`else
        exp_jump_addr = 32'h24;
`endif
        chk("jump_pc", imem_addr, 32'h20);
        imem_rdata = 32'h8000_0010;
        push(imem_rdata, 32'h20);
        step();
        chk("jump_next_addr", imem_addr, exp_jump_addr);
        chk("jump_no_bubble", {31'h0, imem_req}, 32'h1);

        // Branch beats stall and ready; returned word is discarded
        br_taken = 1'b1; br_target = 32'h0000_0103; stall = 1'b1;
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        chk("br_valid0", {31'h0, instr_valid}, 32'h0);
        chk("br_flush_req", {31'h0, imem_req}, 32'h0);
        br_taken = 1'b0; stall = 1'b0; imem_ready = 1'b0;
        step();
        chk("br_valid1", {31'h0, instr_valid}, 32'h0);
        chk("br_addr", imem_addr, 32'h100);
        chk("br_req", {31'h0, imem_req}, 32'h1);

        // Memory not ready for four cycles
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wait_req", {31'h0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, 32'h100);
            chk("wait_valid", {31'h0, instr_valid}, 32'h0);
        end
        imem_ready = 1'b1; imem_rdata = 32'h0800_0100;
        push(imem_rdata, 32'h100);
        step();
        imem_ready = 1'b0;
        chk("wait_done_addr", imem_addr, 32'h104);

        // Branch during FLUSH reloads the pc and stays in FLUSH
        br_taken = 1'b1; br_target = 32'h0000_0300;
        step();
        chk("dbl_addr0", imem_addr, 32'h300);
        br_target = 32'h0000_0401;
        step();
        chk("dbl_addr1", imem_addr, 32'h400);
        chk("dbl_req", {31'h0, imem_req}, 32'h0);
        chk("dbl_valid", {31'h0, instr_valid}, 32'h0);
        br_taken = 1'b0;
        step();
        chk("dbl_fetch_req", {31'h0, imem_req}, 32'h1);
        chk("dbl_fetch_addr", imem_addr, 32'h400);

        // Reset mid-fetch drops the response
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0800_0500;
        step();
        chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_instr", instr_out, 32'h0);
        chk("mid_rst_pc_out", pc_out, 32'h0);
        chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
        rst = 1'b0; imem_ready = 1'b0;
        step();

        // PC wraps past the top of the address space
        br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
        step();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        br_taken = 1'b0;
        step();
        imem_ready = 1'b1; imem_rdata = 32'h0800_0600;
        push(imem_rdata, 32'hFFFF_FFFC);
        step();
        imem_ready = 1'b0;
        chk("wrap_next", imem_addr, 32'h0);
        step(); step();

        chk("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the byte address of the first fetched instruction.
REQ-002 The block SHALL have parameter PC_W, default 32, which is the program counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-006 The block SHALL have port imem_addr, output, PC_W bits: word-aligned fetch byte address.
REQ-007 The block SHALL have port imem_ready, input, 1 bit: imem_rdata is valid this cycle.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: the fetched instruction word.
REQ-009 The block SHALL have port stall, input, 1 bit: downstream cannot accept a new instruction.
REQ-010 The block SHALL have port br_taken, input, 1 bit: execute-stage redirect.
REQ-011 The block SHALL have port br_target, input, PC_W bits: redirect byte address.
REQ-012 The block SHALL have port instr_out, output, 32 bits: the instruction presented to the decode register.
REQ-013 The block SHALL have port instr_valid, output, 1 bit: instr_out holds a real instruction; 0 means bubble.
REQ-014 The block SHALL have port pc_out, output, PC_W bits: the address of instr_out.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, HOLD and FLUSH.
REQ-016 From IDLE, the FSM SHALL go to FETCH unconditionally after one cycle; imem_req=0 in IDLE.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc. On imem_ready=1, the next edge SHALL load instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1 and pc<=pc+4.
REQ-018 In FETCH with imem_ready=0, the block SHALL hold all state and keep imem_req/imem_addr stable until ready.
REQ-019 If stall=1 while instr_valid=1, the block SHALL enter or stay in HOLD: imem_req=0, with instr_out, pc_out, instr_valid and pc frozen.
REQ-020 The block SHALL leave HOLD for FETCH on the first cycle with stall=0.
REQ-021 br_taken=1 SHALL have priority over stall, imem_ready and every state except reset. On that edge: pc<={br_target[PC_W-1:2],2'b00}, instr_valid<=0, and the state becomes FLUSH; any imem_rdata returned that cycle SHALL be discarded.
REQ-022 FLUSH SHALL last exactly one cycle with imem_req=0 and instr_valid=0, then go to FETCH.
REQ-023 br_taken during FLUSH SHALL reload pc from br_target and stay in FLUSH for one further cycle.
REQ-024 The PC SHALL wrap modulo 2^PC_W, with no overflow flag.
REQ-025 Throughput SHALL be one instruction per cycle when imem_ready=1 and stall=0 continuously; fetch-to-instr_valid latency is one edge.

Reset
REQ-026 While rst=1: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_out=0, pc_out=0, instr_valid=0.
REQ-027 rst=1 SHALL override br_taken, stall and imem_ready in any state, including mid-fetch; an in-flight response SHALL be dropped.

Configuration
REQ-028 Macro FETCH_JUMP_PREDECODE_EN: when defined, a captured word with imem_rdata[31:30]=2'b10 (J type) SHALL set the next pc to {pc[PC_W-1:29], imem_rdata[26:0], 2'b00} instead of pc+4, with no bubble; br_taken still has priority.
REQ-029 When FETCH_JUMP_PREDECODE_EN is undefined, J-type words SHALL advance pc by 4 and their redirect SHALL come only via br_taken.

Structure
REQ-030 Package asip_pkg SHALL hold: the instruction-class enum (R=2'b00, I=2'b01, J=2'b10, V=2'b11), the INSTR_W=32 constant, and the fetch FSM state enum.
REQ-031 The next-PC mux (reset/branch/jump/+4/hold) SHALL be a combinational sub-module fetch_pc_gen; the FSM and registers SHALL live in fetch_ctrl.

Verification
REQ-032 Reset then imem_ready=1, 3 cycles, with words 0x0800_0001, 0x0800_0002, 0x0800_0003 -> imem_addr 0x0,0x4,0x8; each word appears on instr_out the cycle after it is fetched, with instr_valid=1 and pc_out 0x0,0x4,0x8.
REQ-033 stall=1 for 3 cycles with instr_valid=1 -> imem_req=0 and instr_out/pc_out unchanged; the stall=0 cycle resumes FETCH at the next address.
REQ-034 br_taken=1 with br_target=0x0000_0103, simultaneous with stall=1 and imem_ready=1 -> instr_valid=0 for 2 cycles, then imem_addr=0x0000_0100.
REQ-035 imem_ready held 0 for 4 cycles -> imem_addr stable and imem_req=1 throughout; no instr_valid pulse.
REQ-036 rst asserted mid-FETCH with imem_ready=1 -> all outputs at reset values the next cycle; the response is not captured.
REQ-037 With FETCH_JUMP_PREDECODE_EN defined, at pc=0x20 and word 0x8000_0010 -> next imem_addr=0x40 with no bubble; with the macro undefined -> next imem_addr=0x24.
